uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Oversampling UART receiver that turns the asynchronous serial line into 9-bit frames: 8 data bits plus the received parity bit. It sits directly upstream of the UART debug interface and drives its `frame` / `frame_valid` inputs. It also flags parity and framing errors for the debug/status path.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, tick rate per bit (fixed at 16; other values unsupported)
PARITY_ODD, 0, 0 = even parity check, 1 = odd parity check

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
frame  out  9  {parity_bit, data[7:0]}; data is reassembled LSB-first
frame_valid  out  1  one-clk pulse; frame is valid and updated this cycle
parity_err  out  1  one-clk pulse coincident with frame_valid when parity check fails
frame_err  out  1  one-clk pulse when the stop bit is sampled low
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - frame=0, frame_valid=0, parity_err=0, frame_err=0, busy=0.
  - State returns to IDLE.
  - Synchroniser flops and sample registers reset to 1; tick and bit counters reset to 0.
  - Reset mid-frame aborts the frame silently.
- Input conditioning: 2-flop synchroniser on rx; rx_s is the synchronised value, used everywhere.
- Tick generation:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, minimum 1.
  - The tick pulses every DIV clks.
  - The divider is cleared on start detection so the sample phase is aligned to the start edge.
- Sample counter scnt (0..15):
  - Advances on each tick; wraps 15->0 at the end of each bit period.
  - Samples are taken at scnt 7, 8 and 9; the bit value is the majority of the three, decided on the tick where scnt=9.
- State machine:
  - IDLE: rx_s==0 -> START, scnt=0, divider cleared.
  - START: at decision, majority 0 -> continue to DATA at wrap (bit index 0). Majority 1 -> false start, back to IDLE immediately.
  - DATA: at each decision, shift the bit into data[idx]. At wrap, idx++; after idx 7 completes -> PARITY.
  - PARITY: store the parity bit at decision; at wrap -> STOP.
  - STOP:
    - Decision 1 -> pulse frame_valid next clk and return to IDLE (early return permits back-to-back frames).
    - Decision 0 -> pulse frame_err next clk, no frame_valid, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then IDLE.
- Parity check:
  - Even: XOR(data, parity_bit) must be 0.
  - Odd: it must be 1.
  - On failure, parity_err pulses together with frame_valid. The frame is still delivered.
- Output holding:
  - frame updates only in the cycle frame_valid=1 and holds between frames.
  - frame_valid, parity_err and frame_err are never high for more than 1 clk.
- Latency: frame_valid is asserted 1 clk after the stop-bit decision tick.
- frame_err and frame_valid are never asserted in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - SAMPLE_A/B/C = 7/8/9
  - DATA_BITS = 8
  - FRAME_W = 9
- One sub-module, uart_baud_tick: divider with synchronous clear input, producing the 1-clk tick.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=100_000 (DIV=1, one bit = 16 clks), PARITY_ODD=0, 5 ns half-period clock.
1. Send 0xAA, parity 0, stop 1 -> one frame_valid pulse, frame=9'b010101010, parity_err=0, busy falls after stop decision.
2. Send 0xB3, parity 0 (bad for even parity) -> frame=9'b010110011, frame_valid and parity_err high in the same single cycle.
3. rx low for 4 clks then high -> no frame_valid or frame_err; busy high for at most 12 clks, then 0.
4. Send 0x55, parity 0, stop bit 0, rx held low 40 clks -> frame_err pulse, frame unchanged, busy stays 1 until rx high. A following 0x0F frame is then received correctly.
5. Two back-to-back frames (0x01 then 0xFE) with no idle gap -> two frame_valid pulses about 176 clks apart, frames 9'b100000001 and 9'b111111110.
6. Assert rst low during data bit 3 -> all outputs 0 immediately. After rst release, the next 0x3C frame gives frame=9'b000111100.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
//   state_e        receiver FSM states
//   SAMPLE_A/B/C   sample-counter positions of the three majority samples
//   DATA_BITS      data bits per frame
//   FRAME_W        delivered frame width {parity_bit, data}
//   maj3()         two-of-three majority vote
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  localparam int unsigned SAMPLE_A  = 7;
  localparam int unsigned SAMPLE_B  = 8;
  localparam int unsigned SAMPLE_C  = 9;
  localparam int unsigned SCNT_W    = 4;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned FRAME_W   = DATA_BITS + 1;
  localparam int unsigned IDX_W     = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clk tick every DIV clks.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear; restarts the divide period (no tick while high)
//   tick_o  one-clk pulse every DIV clks
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = ~clr_i & (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x oversampling UART receiver delivering 9-bit frames
// {parity_bit, data[7:0]} (data LSB-first on the line) with parity and
// framing error flags.
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   frame        last received {parity_bit, data}; holds between frames
//   frame_valid  one-clk pulse, frame updated this cycle
//   parity_err   one-clk pulse with frame_valid when the parity check fails
//   frame_err    one-clk pulse when the stop bit is sampled low
//   busy         high whenever the receiver is not idle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               busy
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam logic        ODD     = (PARITY_ODD != 0);

  localparam logic [SCNT_W-1:0] S_A  = SCNT_W'(SAMPLE_A);
  localparam logic [SCNT_W-1:0] S_B  = SCNT_W'(SAMPLE_B);
  localparam logic [SCNT_W-1:0] S_C  = SCNT_W'(SAMPLE_C);
  localparam logic [SCNT_W-1:0] S_LAST = '1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Synchroniser
  logic rx_meta_q, rx_s_q;

  // FSM and datapath state
  state_e                 state_q, state_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   samp_a_q, samp_a_d;
  logic                   samp_b_q, samp_b_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_q, par_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;

  logic baud_clr;
  logic tick;
  logic decide;
  logic wrap;
  logic bit_val;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign decide  = tick && (scnt_q == S_C);
  assign wrap    = tick && (scnt_q == S_LAST);
  // Third vote is the live sample taken on the decision tick itself.
  assign bit_val = maj3(samp_a_q, samp_b_q, rx_s_q);

  always_comb begin
    state_d       = state_q;
    scnt_d        = scnt_q;
    idx_d         = idx_q;
    samp_a_d      = samp_a_q;
    samp_b_d      = samp_b_q;
    data_d        = data_q;
    par_d         = par_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    baud_clr      = 1'b0;

    if ((state_q != IDLE) && (state_q != WAIT_IDLE) && tick) begin
      scnt_d = scnt_q + 1'b1;
      if (scnt_q == S_A) samp_a_d = rx_s_q;
      if (scnt_q == S_B) samp_b_d = rx_s_q;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d  = START;
          scnt_d   = '0;
          baud_clr = 1'b1;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (decide) data_d[idx_q] = bit_val;
        if (wrap) begin
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (decide) par_d = bit_val;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop decision rather than the wrap so a following
        // start edge half a bit later is not missed.
        if (decide) begin
          if (bit_val) begin
            frame_d       = {par_q, data_q};
            frame_valid_d = 1'b1;
            parity_err_d  = ((^data_q) ^ par_q) != ODD;
            state_d       = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      scnt_q        <= '0;
      idx_q         <= '0;
      samp_a_q      <= 1'b1;
      samp_b_q      <= 1'b1;
      data_q        <= '0;
      par_q         <= 1'b0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      idx_q         <= idx_d;
      samp_a_q      <= samp_a_d;
      samp_b_q      <= samp_b_d;
      data_q        <= data_d;
      par_q         <= par_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [8:0] frame;
  logic       frame_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic [8:0] frame;
    logic       perr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned err_exp = 0;
  logic [8:0]  last_frame = '0;
  int unsigned fv_cyc[$];
  logic        prev_fv = 1'b0;

  uart_rx_frame #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16),
    .PARITY_ODD(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .frame      (frame),
    .frame_valid(frame_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_valid) begin
        check("fv_single_cycle", {31'd0, prev_fv}, 32'd0);
        check("fv_no_frame_err", {31'd0, frame_err}, 32'd0);
        check("busy_low_at_fv", {31'd0, busy}, 32'd0);
        fv_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame_valid", {23'd0, frame}, 32'h1ff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame", {23'd0, frame}, {23'd0, e.frame});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          last_frame = e.frame;
        end
      end else if (parity_err) begin
        check("perr_without_fv", {31'd0, parity_err}, 32'd0);
      end
      if (frame_err) begin
        if (err_exp == 0) begin
          check("unexpected_frame_err", {31'd0, frame_err}, 32'd0);
        end else begin
          err_exp--;
          check("frame_held_on_ferr", {23'd0, frame}, {23'd0, last_frame});
          check("busy_at_ferr", {31'd0, busy}, 32'd1);
        end
      end
      prev_fv = frame_valid;
    end else begin
      prev_fv = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic [8:0] exp_frame,
                            input logic exp_perr);
    exp_t e;
    e.frame = exp_frame;
    e.perr  = exp_perr;
    exp_q.push_back(e);
    send_bits(d, par, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame"}, {23'd0, frame}, 32'd0);
    check({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
    check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int unsigned busy_cnt;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0xAA, good even parity
    send_frame(8'hAA, 1'b0, 9'b0_1010_1010, 1'b0);
    repeat (8) @(negedge clk);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: 0xB3 with parity 0 fails the even check but is still delivered
    send_frame(8'hB3, 1'b0, 9'b0_1011_0011, 1'b1);
    repeat (8) @(negedge clk);

    // 3: short glitch is a false start
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t3_busy_nonzero", {31'd0, (busy_cnt > 0)}, 32'd1);
    check("t3_busy_le12", {31'd0, (busy_cnt <= 12)}, 32'd1);
    check("t3_busy_end", {31'd0, busy}, 32'd0);

    // 4: stop bit low, line held low, then recovery
    err_exp++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d55;
      d55 = 8'h55;
      drive_bit(d55[i]);
    end
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_ferr_seen", err_exp, 32'd0);
    check("t4_busy_wait", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_busy_released", {31'd0, busy}, 32'd0);
    send_frame(8'h0F, 1'b0, 9'b0_0000_1111, 1'b0);
    repeat (8) @(negedge clk);

    // 5: back-to-back frames, no idle gap
    fv_cyc.delete();
    send_frame(8'h01, 1'b1, 9'b1_0000_0001, 1'b0);
    send_frame(8'hFE, 1'b1, 9'b1_1111_1110, 1'b0);
    repeat (8) @(negedge clk);
    check("t5_two_pulses", fv_cyc.size(), 32'd2);
    if (fv_cyc.size() == 2) check("t5_spacing", fv_cyc[1] - fv_cyc[0], 32'd176);

    // 6: reset during data bit 3 aborts silently
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    last_frame = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h3C, 1'b0, 9'b0_0011_1100, 1'b0);
    repeat (20) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("ferr_drained", err_exp, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
